// File: rtl/selecao_de_produto.sv
// Product selection and vend stage: synchronizes the buttons, checks the price against saldo_in
// and holds the spend and dispense outputs long enough for the divided-clock balance controller.
// Optional CONTADOR_VENDAS_EN adds a saturating 8-bit count of successful vends on port vendas.
module selecao_de_produto #(
    parameter int unsigned PRICE0      = 5,
    parameter int unsigned PRICE1      = 10,
    parameter int unsigned PRICE2      = 15,
    parameter int unsigned PRICE3      = 25,
    parameter int unsigned HOLD_CYCLES = 33554432
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] saldo_in,
    input  logic [3:0] btn,
    output logic [5:0] gasto_out,
    output logic [3:0] dispensa,
    output logic       negado,
`ifdef CONTADOR_VENDAS_EN
    output logic [7:0] vendas,
`endif
    output logic       busy
);

    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StVend,
        StClear,
        StDenied
    } state_e;

    function automatic logic [5:0] price_of(input logic [1:0] i);
        logic [5:0] p;
        unique case (i)
            2'd0: p = 6'(PRICE0);
            2'd1: p = 6'(PRICE1);
            2'd2: p = 6'(PRICE2);
            2'd3: p = 6'(PRICE3);
        endcase
        return p;
    endfunction

    state_e           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       sync1_q, sync2_q, prev_q;
    logic [1:0]       vld_q;
    logic [3:0]       press;
    logic [1:0]       press_idx;
    logic             press_any;
    logic             hold_done;
    logic [5:0]       gasto_d;
    logic [3:0]       dispensa_d;
    logic             negado_d;
    logic             busy_d;

    // The synchronizers are preset to "released", so edges are only trusted once real samples
    // have reached prev_q; a button already held through reset therefore never fires.
    always_comb begin
        press     = (vld_q == 2'd3) ? (prev_q & ~sync2_q) : 4'b0000;
        press_any = |press;
        press_idx = 2'd0;
        if (press[0])      press_idx = 2'd0;
        else if (press[1]) press_idx = 2'd1;
        else if (press[2]) press_idx = 2'd2;
        else if (press[3]) press_idx = 2'd3;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        hold_done = (cnt_q == HOLD_LAST);
        case (state_q)
            StIdle: begin
                if (press_any) begin
                    idx_d   = press_idx;
                    state_d = StCheck;
                end
            end
            StCheck:  state_d = (price_of(idx_q) <= saldo_in) ? StVend : StDenied;
            StVend:   if (hold_done) state_d = StClear;
            StClear:  if (hold_done) state_d = StIdle;
            StDenied: if (hold_done) state_d = StIdle;
            default: begin
                state_d = StIdle;
                idx_d   = 2'd0;
            end
        endcase

        // Counter only runs in the hold states and restarts on every state change.
        if (state_d != state_q || state_q == StIdle || state_q == StCheck) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // Outputs are decoded from the next state so they are registered with it.
        gasto_d    = 6'd0;
        dispensa_d = 4'b0000;
        negado_d   = 1'b0;
        busy_d     = (state_d != StIdle);
        case (state_d)
            StVend: begin
                gasto_d    = price_of(idx_d);
                dispensa_d = 4'b0001 << idx_d;
            end
            StDenied: negado_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            idx_q     <= 2'd0;
            cnt_q     <= '0;
            sync1_q   <= 4'b1111;
            sync2_q   <= 4'b1111;
            prev_q    <= 4'b1111;
            vld_q     <= 2'd0;
            gasto_out <= 6'd0;
            dispensa  <= 4'b0000;
            negado    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            sync1_q   <= btn;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            if (vld_q != 2'd3) vld_q <= vld_q + 2'd1;
            gasto_out <= gasto_d;
            dispensa  <= dispensa_d;
            negado    <= negado_d;
            busy      <= busy_d;
        end
    end

`ifdef CONTADOR_VENDAS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            vendas <= 8'd0;
        end else if (state_d == StVend && state_q != StVend && vendas != 8'hFF) begin
            vendas <= vendas + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_selecao_de_produto.sv
// Self-checking bench for selecao_de_produto with a short hold time; each purchase is checked
// cycle by cycle against a timeline computed from the price table and the balance.
module tb_selecao_de_produto;

    localparam int unsigned HOLD = 4;

    logic       clock;
    logic       reset;
    logic [5:0] saldo_in;
    logic [3:0] btn;
    logic [5:0] gasto_out;
    logic [3:0] dispensa;
    logic       negado;
    logic       busy;
`ifdef CONTADOR_VENDAS_EN
    logic [7:0] vendas;
`endif

    int total = 0;
    int bad   = 0;
    int nvend = 0;
    int prices[4] = '{5, 10, 15, 25};

    selecao_de_produto #(
        .PRICE0     (5),
        .PRICE1     (10),
        .PRICE2     (15),
        .PRICE3     (25),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .saldo_in (saldo_in),
        .btn      (btn),
        .gasto_out(gasto_out),
        .dispensa (dispensa),
        .negado   (negado),
`ifdef CONTADOR_VENDAS_EN
        .vendas   (vendas),
`endif
        .busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Press the buttons in mask with balance s; late_mask is additionally pressed and the balance
    // changed to s_late mid-vend, both of which must have no effect.
    task automatic purchase(input logic [3:0] mask, input logic [5:0] s,
                            input logic [3:0] late_mask, input logic [5:0] s_late);
        int  w;
        int  p;
        bit  ok;
        bit  act;
        int  exp_g;
        int  exp_d;
        bit  exp_n;
        bit  exp_b;
        w = 0;
        for (int i = 3; i >= 0; i--) if (mask[i]) w = i;
        p  = prices[w];
        ok = (p <= int'(s));
        @(negedge clock);
        saldo_in = s;
        btn      = ~mask;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clock);
            #1;
            act   = (k >= 4 && k < 4 + int'(HOLD));
            exp_g = (ok && act) ? p : 0;
            exp_d = (ok && act) ? (1 << w) : 0;
            exp_n = !ok && act;
            exp_b = (k >= 3) && (k < 4 + (ok ? 2 : 1) * int'(HOLD));
            chk("gasto_out", 8'(gasto_out), 8'(exp_g));
            chk("dispensa", 8'(dispensa), 8'(exp_d));
            chk("negado", 8'(negado), 8'(exp_n));
            chk("busy", 8'(busy), 8'(exp_b));
            if (k == 5) begin
                btn      = btn & ~late_mask;
                saldo_in = s_late;
            end
        end
        if (ok) nvend++;
        btn = 4'hF;
        repeat (4) @(posedge clock);
    endtask

    initial begin
        reset    = 1'b1;
        btn      = 4'b0000;
        saldo_in = 6'd50;

        // Buttons held through reset must not cause a vend afterwards.
        repeat (2) @(posedge clock);
        #1;
        chk("rst_gasto", 8'(gasto_out), 8'd0);
        chk("rst_dispensa", 8'(dispensa), 8'd0);
        chk("rst_negado", 8'(negado), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clock);
            #1;
            chk("held_busy", 8'(busy), 8'd0);
            chk("held_gasto", 8'(gasto_out), 8'd0);
        end
        btn = 4'hF;
        repeat (4) @(posedge clock);

        purchase(4'b0010, 6'd20, 4'b0000, 6'd10);   // normal vend, balance debited mid-vend
        purchase(4'b1000, 6'd10, 4'b0000, 6'd10);   // insufficient
        purchase(4'b0100, 6'd15, 4'b0000, 6'd15);   // price equals balance
        purchase(4'b0101, 6'd50, 4'b1000, 6'd50);   // priority, late press ignored
        purchase(4'b0001, 6'd50, 4'b0000, 6'd45);   // back-to-back identical
        purchase(4'b0001, 6'd50, 4'b0000, 6'd45);
        purchase(4'b0001, 6'd0, 4'b0000, 6'd0);     // zero balance

        // Reset during VEND.
        @(negedge clock);
        saldo_in = 6'd20;
        btn      = 4'b1101;
        repeat (5) @(posedge clock);
        #1;
        chk("pre_rst_gasto", 8'(gasto_out), 8'd10);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("midrst_gasto", 8'(gasto_out), 8'd0);
        chk("midrst_dispensa", 8'(dispensa), 8'd0);
        chk("midrst_busy", 8'(busy), 8'd0);
        nvend = 0;
        @(negedge clock);
        reset = 1'b0;
        btn   = 4'hF;
        repeat (6) @(posedge clock);

        for (int n = 0; n < 24; n++) begin
            purchase(4'($urandom_range(1, 15)), 6'($urandom_range(0, 63)),
                     4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)));
        end

`ifdef CONTADOR_VENDAS_EN
        chk("vendas", vendas, 8'((nvend > 255) ? 255 : nvend));
        for (int n = 0; n < 256; n++) purchase(4'b0001, 6'd63, 4'b0000, 6'd63);
        chk("vendas_sat", vendas, 8'((nvend > 255) ? 255 : nvend));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
